// File: rtl/event_count_sched.sv
// event_count_sched: edge-detected event requesters served round-robin into one shared counter.
// Optional build macro EVENT_COUNT_SCHED_SAT_EN makes the counter saturate instead of wrapping.
module event_count_sched #(
  parameter int NREQ = 4,
  parameter int CW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] ev,
  input  logic [NREQ-1:0] edge_mode,
  input  logic            enable,
  input  logic            clr,
  output logic [CW-1:0]   cnt,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] pend,
  output logic [NREQ-1:0] drop
);

  localparam int RW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int RW1 = RW + 1;

  logic [NREQ-1:0] ev_q;
  logic [NREQ-1:0] pend_q, pend_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] drop_q, drop_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   rr_q, rr_d;
  logic [RW-1:0]   sel_s;
  logic [RW1-1:0]  idx_s;
  logic [NREQ-1:0] detect_s;
  logic            found_s;

  // Posedge-only requesters see rising edges; the rest see any change.
  assign detect_s = (edge_mode & ev & ~ev_q) | (~edge_mode & (ev ^ ev_q));

  always_comb begin
    found_s = 1'b0;
    sel_s   = '0;
    idx_s   = '0;
    if (enable && !clr && (|pend_q)) begin
      for (int k = 0; k < NREQ; k++) begin
        idx_s = {1'b0, rr_q} + RW1'(k);
        idx_s = (idx_s >= RW1'(NREQ)) ? (idx_s - RW1'(NREQ)) : idx_s;
        if (!found_s && pend_q[idx_s[RW-1:0]]) begin
          found_s = 1'b1;
          sel_s   = idx_s[RW-1:0];
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      found_s = 1'b0;
    end
  end

  always_comb begin
    grant_d = '0;
    pend_d  = pend_q | detect_s;
    drop_d  = detect_s & pend_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (found_s) begin
      grant_d[sel_s] = 1'b1;
      // A fresh event on the granted requester replaces the consumed one.
      pend_d = (pend_q & ~grant_d) | detect_s;
      drop_d = detect_s & pend_q & ~grant_d;
      rr_d   = (sel_s == RW'(NREQ - 1)) ? '0 : (sel_s + RW'(1));
`ifdef EVENT_COUNT_SCHED_SAT_EN
      cnt_d  = (cnt_q == {CW{1'b1}}) ? cnt_q : (cnt_q + CW'(1));
`else
      cnt_d  = cnt_q + CW'(1);
`endif
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_q    <= '0;
      pend_q  <= '0;
      grant_q <= '0;
      drop_q  <= '0;
      cnt_q   <= '0;
      rr_q    <= '0;
    end else begin
      ev_q    <= ev;
      pend_q  <= pend_d;
      grant_q <= grant_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

  assign cnt   = cnt_q;
  assign grant = grant_q;
  assign pend  = pend_q;
  assign drop  = drop_q;

endmodule

// File: tb/tb_event_count_sched.sv
// Directed-vector bench for event_count_sched (NREQ=4, CW=8); expected values are hand-computed.
module tb_event_count_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] ev = 4'b0000;
  logic [3:0] edge_mode = 4'b0000;
  logic       enable = 1'b1;
  logic       clr = 1'b0;
  logic [7:0] cnt;
  logic [3:0] grant;
  logic [3:0] pend;
  logic [3:0] drop;
  logic [7:0] wrap_exp;

  int n_chk  = 0;
  int n_fail = 0;

  event_count_sched #(.NREQ(4), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .ev(ev), .edge_mode(edge_mode),
    .enable(enable), .clr(clr), .cnt(cnt), .grant(grant), .pend(pend), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
`ifdef EVENT_COUNT_SCHED_SAT_EN
    wrap_exp = 8'd255;
`else
    wrap_exp = 8'd0;
`endif
    #2 rst_n = 1'b0;
    #10;
    check("rst_cnt",   32'(cnt),   32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_pend",  32'(pend),  32'd0);
    check("rst_drop",  32'(drop),  32'd0);
    rst_n = 1'b1;
    tick(1);

    // single event: pend after edge 1, grant and count after edge 2
    ev = 4'b0001;
    tick(1);
    check("t1_pend",  32'(pend),  32'b0001);
    check("t1_cnt0",  32'(cnt),   32'd0);
    tick(1);
    check("t1_grant", 32'(grant), 32'b0001);
    check("t1_cnt1",  32'(cnt),   32'd1);
    check("t1_clr",   32'(pend),  32'b0000);

    // posedge-only mode: pulse counts once
    edge_mode = 4'b0100;
    ev = 4'b0101;
    tick(1);
    check("t2_pend",  32'(pend),  32'b0100);
    ev = 4'b0001;
    tick(1);
    check("t2_grant", 32'(grant), 32'b0100);
    tick(2);
    check("t2_cnt",   32'(cnt),   32'd2);
    check("t2_pend0", 32'(pend),  32'b0000);
    // any-change mode: same pulse counts twice
    edge_mode = 4'b0000;
    ev = 4'b0101;
    tick(1);
    ev = 4'b0001;
    tick(1);
    check("t2b_pend", 32'(pend),  32'b0100);
    check("t2b_cnt3", 32'(cnt),   32'd3);
    tick(2);
    check("t2b_cnt4", 32'(cnt),   32'd4);
    check("t2b_gnt0", 32'(grant), 32'd0);

    // three simultaneous requesters from rr=0
    ev = 4'b0000;
    pulse_reset();
    ev = 4'b1011;
    tick(1);
    check("t3_pend",   32'(pend),  32'b1011);
    tick(1);
    check("t3_g0",     32'(grant), 32'b0001);
    check("t3_c1",     32'(cnt),   32'd1);
    tick(1);
    check("t3_g1",     32'(grant), 32'b0010);
    check("t3_c2",     32'(cnt),   32'd2);
    tick(1);
    check("t3_g3",     32'(grant), 32'b1000);
    check("t3_c3",     32'(cnt),   32'd3);
    check("t3_pend0",  32'(pend),  32'b0000);
    // disabled: pend held, no grants
    ev = 4'b0000;
    pulse_reset();
    enable = 1'b0;
    ev = 4'b1011;
    tick(4);
    check("t3d_pend",  32'(pend),  32'b1011);
    check("t3d_grant", 32'(grant), 32'd0);
    check("t3d_cnt",   32'(cnt),   32'd0);

    // drop on a second event while pending and disabled
    ev = 4'b0000;
    pulse_reset();
    enable = 1'b0;
    ev = 4'b0010;
    tick(1);
    check("t4_pend",  32'(pend), 32'b0010);
    check("t4_nodrp", 32'(drop), 32'b0000);
    ev = 4'b0000;
    tick(1);
    check("t4_drop",  32'(drop), 32'b0010);
    check("t4_pend1", 32'(pend), 32'b0010);
    tick(1);
    check("t4_drop0", 32'(drop), 32'b0000);
    enable = 1'b1;
    tick(1);
    check("t4_grant", 32'(grant), 32'b0010);
    check("t4_cnt",   32'(cnt),   32'd1);

    // clr wins over a grant in the same cycle
    ev = 4'b0001;
    tick(1);
    clr = 1'b1;
    tick(1);
    check("t5_clr_cnt",  32'(cnt),   32'd0);
    check("t5_clr_gnt",  32'(grant), 32'd0);
    check("t5_clr_pend", 32'(pend),  32'b0001);
    clr = 1'b0;
    tick(1);
    check("t5_post_gnt", 32'(grant), 32'b0001);
    check("t5_post_cnt", 32'(cnt),   32'd1);

    // count up to 255 then one more event
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("t6_zero", 32'(cnt), 32'd0);
    for (int i = 0; i < 255; i++) begin
      ev[0] = ~ev[0];
      tick(1);
    end
    tick(1);
    check("t6_max",  32'(cnt), 32'd255);
    tick(1);
    ev[0] = ~ev[0];
    tick(2);
    check("t6_wrap_gnt", 32'(grant), 32'b0001);
    check("t6_wrap",     32'(cnt),   32'(wrap_exp));
    check("t6_pend",     32'(pend),  32'b0000);

    // async reset mid-operation
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ev[0] = ~ev[0];
      tick(1);
    end
    tick(1);
    check("t7_cnt5", 32'(cnt), 32'd5);
    enable = 1'b0;
    ev = ev ^ 4'b0110;
    tick(1);
    check("t7_pend", 32'(pend), 32'b0110);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_cnt",   32'(cnt),   32'd0);
    check("t7_rst_pend",  32'(pend),  32'd0);
    check("t7_rst_grant", 32'(grant), 32'd0);
    check("t7_rst_drop",  32'(drop),  32'd0);
    ev = 4'b0001;
    enable = 1'b1;
    #2 rst_n = 1'b1;
    tick(1);
    check("t7_rel_pend", 32'(pend), 32'b0001);
    check("t7_rel_cnt0", 32'(cnt),  32'd0);
    tick(1);
    check("t7_rel_cnt1", 32'(cnt),   32'd1);
    check("t7_rel_gnt",  32'(grant), 32'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/event_count_sched.md
EVENT_COUNT_SCHED -- requirements
Module: event_count_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of event requesters (2..16).
REQ-002 SHALL have parameter CW, default 8, shared counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous assert and active-low.
REQ-005 SHALL have port ev, input, NREQ, raw event lines, one per requester.
REQ-006 SHALL have port edge_mode, input, NREQ, per requester: 1 = posedge only, 0 = any change.
REQ-007 SHALL have port enable, input, 1, grants allowed when 1.
REQ-008 SHALL have port clr, input, 1, synchronous counter clear.
REQ-009 SHALL have port cnt, output, CW, shared event counter.
REQ-010 SHALL have port grant, output, NREQ, registered one-hot grant; all zero when no grant.
REQ-011 SHALL have port pend, output, NREQ, pending-event flags.
REQ-012 SHALL have port drop, output, NREQ, one-cycle pulse per lost event.

Function
REQ-013 SHALL register ev into ev_q every cycle; detect[i] = edge_mode[i] ? (ev[i] & ~ev_q[i]) : (ev[i] ^ ev_q[i]).
REQ-014 SHALL set pend[i] at the edge where detect[i] is 1, so pend rises one edge after the ev transition is sampled.
REQ-015 SHALL, when enable=1, clr=0 and pend is nonzero, select one requester round-robin, starting at pointer rr and searching upward modulo NREQ.
REQ-016 SHALL, at the next edge, drive grant one-hot for the selected requester, clear its pend bit, increment cnt by 1, and set rr to (selected+1) mod NREQ.
REQ-017 SHALL give one grant and one increment per cycle at most; latency from pend set to cnt update is one cycle when uncontended.
REQ-018 SHALL keep pend[i]=1 with no drop when detect[i] coincides with a grant to i; the new event replaces the consumed one.
REQ-019 SHALL pulse drop[i] for one cycle and leave pend[i]=1 when detect[i]=1 while pend[i]=1 and i is not granted.
REQ-020 SHALL, when clr=1, load cnt=0, drive grant=0, and leave pend and rr unchanged; clr overrides an increment in the same cycle.
REQ-021 SHALL hold pend, rr and cnt and drive grant=0 when enable=0; detection and drop continue.
REQ-022 SHALL wrap cnt from 2^CW-1 to 0 on increment (see REQ-026).

Reset
REQ-023 SHALL, while rst_n=0, force ev_q=0, pend=0, grant=0, drop=0, cnt=0 and rr=0 regardless of clk.
REQ-024 SHALL treat ev high at reset release as a detected event on the first edge, because ev_q=0.
REQ-025 SHALL, when reset asserts mid-operation, discard all pending events with no drop pulse.

Configuration
REQ-026 SHALL, with macro EVENT_COUNT_SCHED_SAT_EN defined, saturate cnt at 2^CW-1; grants at saturation still clear pend and advance rr, with no increment. Without the macro, REQ-022 wrap applies.

Verification
REQ-027 SHALL cover: after reset, ev=0000 with edge_mode=0000, then ev[0] 0->1 -> pend[0]=1 after edge 1; grant=0001 and cnt=1 after edge 2.
REQ-028 SHALL cover: edge_mode[2]=1, ev[2] 0->1->0 over two cycles -> cnt increments exactly once; with edge_mode[2]=0, the same stimulus -> cnt increments twice.
REQ-029 SHALL cover: ev[0], ev[1] and ev[3] rise in the same cycle with rr=0 -> grant sequence 0001, 0010, 1000 and cnt +3 over 3 cycles; with enable=0 held throughout, no grants occur and pend=1011 is held.
REQ-030 SHALL cover: edge_mode[1]=0, ev[1] toggles on 2 consecutive edges while enable=0 -> drop[1] pulses once, and cnt +1 after enable is set to 1.
REQ-031 SHALL cover: cnt=255 (CW=8) with one grant -> cnt=0 without the macro, cnt=255 with EVENT_COUNT_SCHED_SAT_EN; clr=1 coinciding with a grant -> cnt=0, grant=0, pend retained.
REQ-032 SHALL cover: rst_n pulsed low between clk edges while pend=0110 and cnt=5 -> all outputs 0 immediately; ev held at 0001 through release -> cnt=1 two edges after release.
